// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-requester ALU arbiter.
`timescale 1ns/1ps
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: and/or/add/sub/unsigned-slt/nor; unknown codes give 0.
`timescale 1ns/1ps
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] di1,
  input  logic [WIDTH-1:0] di2,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  // Select the operation; arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    out = '0;
    case (alu_ctr)
      ALU_AND: out = di1 & di2;
      ALU_OR:  out = di1 | di2;
      ALU_ADD: out = di1 + di2;
      ALU_SUB: out = di1 - di2;
      ALU_SLT: out = {{(WIDTH-1){1'b0}}, (di1 < di2)};
      ALU_NOR: out = ~(di1 | di2);
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation takes IDLE (handshake) -> EXEC (ALU evaluates) -> RESP
// (one-cycle response pulse to the owner).
`timescale 1ns/1ps
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctr,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctr,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero
);

  arb_state_t       state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [3:0]       ctr_q, ctr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;

  logic             any_req;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .alu_ctr (ctr_q),
    .di1     (a_q),
    .di2     (b_q),
    .out     (alu_out),
    .zero    (alu_zero)
  );

  // Pick the winner: on a tie the requester not served last wins.
  always_comb begin
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else begin
      grant = req1_valid;
    end
    accept = (state_q == IDLE) && any_req;
  end

  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  assign rsp0_valid  = (state_q == RESP) && !owner_q;
  assign rsp1_valid  = (state_q == RESP) && owner_q;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;

  // Next-state, operand capture and result capture.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    ctr_d   = ctr_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant;
          ctr_d   = grant ? req1_ctr : req0_ctr;
          a_d     = grant ? req1_a   : req0_a;
          b_d     = grant ? req1_b   : req0_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_out;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      ctr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      ctr_q   <= ctr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_ctr = '0, req1_ctr = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctr(req0_ctr),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctr(req1_ctr),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Response log for the directed scenarios.
  int          log_port[$];
  int          log_cyc[$];
  logic [31:0] log_res[$];
  logic        log_zero[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference semantics of each ALU code, returned as {zero, result}.
  function automatic logic [32:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'b0110: r = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      4'b0111: r = (a < b) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // Transaction model: the shared unit is free again 3 cycles after a grant,
  // the winner's response is due 2 cycles after its grant.
  bit          m_last = 1'b1;
  int          m_free = 0;
  bit          p_vld = 1'b0;
  int          p_due = 0;
  bit          p_own = 1'b0;
  logic [32:0] p_exp = '0;

  task automatic model_step();
    bit e_r0, e_r1, e_v0, e_v1, win, gnt;
    if (rsp0_valid) begin
      log_port.push_back(0); log_cyc.push_back(cyc);
      log_res.push_back(rsp0_result); log_zero.push_back(rsp0_zero);
    end
    if (rsp1_valid) begin
      log_port.push_back(1); log_cyc.push_back(cyc);
      log_res.push_back(rsp1_result); log_zero.push_back(rsp1_zero);
    end
    if (rst) begin
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_ready1", 32'(req1_ready), 32'd0);
      chk("rst_rsp0", 32'(rsp0_valid), 32'd0);
      chk("rst_rsp1", 32'(rsp1_valid), 32'd0);
      p_vld = 1'b0; m_last = 1'b1; m_free = 0;
      return;
    end
    gnt = (cyc >= m_free) && (req0_valid || req1_valid);
    win = (req0_valid && req1_valid) ? !m_last : req1_valid;
    e_r0 = gnt && !win;
    e_r1 = gnt && win;
    e_v0 = p_vld && (p_due == cyc) && !p_own;
    e_v1 = p_vld && (p_due == cyc) && p_own;
    chk("ready0", 32'(req0_ready), 32'(e_r0));
    chk("ready1", 32'(req1_ready), 32'(e_r1));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
    if (e_v0) begin
      chk("rsp0_result", rsp0_result, p_exp[31:0]);
      chk("rsp0_zero", 32'(rsp0_zero), 32'(p_exp[32]));
    end
    if (e_v1) begin
      chk("rsp1_result", rsp1_result, p_exp[31:0]);
      chk("rsp1_zero", 32'(rsp1_zero), 32'(p_exp[32]));
    end
    if (p_vld && p_due == cyc) p_vld = 1'b0;
    if (gnt) begin
      m_free = cyc + 3;
      m_last = win;
      p_vld  = 1'b1;
      p_due  = cyc + 2;
      p_own  = win;
      p_exp  = win ? ref_alu(req1_ctr, req1_a, req1_b) : ref_alu(req0_ctr, req0_a, req0_b);
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input bit v, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
    if (idx == 0) begin
      req0_valid = v; req0_ctr = c; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_ctr = c; req1_a = a; req1_b = b;
    end
  endtask

  task automatic drop_valid(input int idx);
    if (idx == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  // Present one operation and hold it until accepted (or cancelled).
  task automatic issue(input int idx, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input bit keep, input int maxw,
                       input bit may_cancel, output int hs);
    bit rdy;
    hs = -1;
    set_req(idx, 1'b1, c, a, b);
    for (int i = 0; i < maxw; i++) begin
      #1;
      rdy = (idx == 0) ? req0_ready : req1_ready;
      if (rdy) begin
        hs = cyc;
        step();
        if (!keep) drop_valid(idx);
        return;
      end
      step();
    end
    drop_valid(idx);
    if (!may_cancel) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout req%0d: no ready within %0d cycles", idx, maxw);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    log_port.delete(); log_cyc.delete(); log_res.delete(); log_zero.delete();
  endtask

  task automatic clear_log();
    log_port.delete(); log_cyc.delete(); log_res.delete(); log_zero.delete();
  endtask

  task automatic chk_log(input string name, input int k, input int port, input int at,
                         input logic [31:0] res, input bit z);
    if (log_port.size() > k) begin
      chk({name, "_port"}, 32'(log_port[k]), 32'(port));
      chk({name, "_cycle"}, 32'(log_cyc[k]), 32'(at));
      chk({name, "_result"}, log_res[k], res);
      chk({name, "_zero"}, 32'(log_zero[k]), 32'(z));
    end else begin
      checks++;
      errors++;
      $display("FAIL %s_missing: got %0d responses needed more than %0d", name, log_port.size(), k);
    end
  endtask

  task automatic pick_op(output logic [3:0] c, output logic [31:0] a, output logic [31:0] b);
    logic [3:0] codes [7];
    codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, 4'b0000};
    codes[6] = 4'($urandom_range(0, 15));
    c = codes[$urandom_range(0, 6)];
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 5))
      0: b = a;
      1: a = 32'hFFFF_FFFF;
      2: begin a = 32'd0; b = 32'd0; end
      default: ;
    endcase
  endtask

  task automatic drive_random(input int idx, input int n);
    logic [3:0]  c;
    logic [31:0] a, b;
    int hs;
    bit cancel;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) step();
      pick_op(c, a, b);
      cancel = ($urandom_range(0, 9) == 0);
      issue(idx, c, a, b, 1'b0, cancel ? int'($urandom_range(1, 3)) : 12, cancel, hs);
    end
  endtask

  int h0, h1, h2, h3;

  initial begin
    step();
    step();
    rst = 1'b0;

    // Reset state and idle behaviour.
    do_reset();
    repeat (5) step();
    chk("idle_result", rsp0_result, 32'd0);
    chk("idle_zero", 32'(rsp1_zero), 32'd0);
    chk("idle_no_rsp", 32'(log_port.size()), 32'd0);

    // Requester 0 alone: 5 + 7.
    issue(0, ALU_ADD, 32'd5, 32'd7, 1'b0, 10, 1'b0, h0);
    repeat (4) step();
    chk("add_count", 32'(log_port.size()), 32'd1);
    chk_log("add", 0, 0, h0 + 2, 32'd12, 1'b0);

    // Simultaneous requests after reset: requester 0 wins the tie.
    do_reset();
    fork
      issue(0, ALU_SUB, 32'd9, 32'd9, 1'b0, 10, 1'b0, h0);
      issue(1, ALU_OR, 32'hF0, 32'h0F, 1'b0, 10, 1'b0, h1);
    join
    repeat (4) step();
    chk("tie_count", 32'(log_port.size()), 32'd2);
    chk_log("tie_r0", 0, 0, h0 + 2, 32'd0, 1'b1);
    chk_log("tie_r1", 1, 1, h0 + 5, 32'hFF, 1'b0);

    // Both held continuously: grants alternate 0,1,0,1.
    do_reset();
    fork
      begin
        issue(0, ALU_ADD, 32'd1, 32'd1, 1'b1, 10, 1'b0, h0);
        issue(0, ALU_ADD, 32'd3, 32'd3, 1'b0, 10, 1'b0, h2);
      end
      begin
        issue(1, ALU_ADD, 32'd2, 32'd2, 1'b1, 10, 1'b0, h1);
        issue(1, ALU_ADD, 32'd4, 32'd4, 1'b0, 10, 1'b0, h3);
      end
    join
    repeat (4) step();
    chk_log("rr0", 0, 0, h0 + 2, 32'd2, 1'b0);
    chk_log("rr1", 1, 1, h0 + 5, 32'd4, 1'b0);
    chk_log("rr2", 2, 0, h0 + 8, 32'd6, 1'b0);
    chk_log("rr3", 3, 1, h0 + 11, 32'd8, 1'b0);

    // Requester 1: unsigned slt, then an undefined code.
    clear_log();
    issue(1, ALU_SLT, 32'd3, 32'd8, 1'b0, 10, 1'b0, h0);
    issue(1, 4'b1111, 32'd5, 32'd6, 1'b0, 10, 1'b0, h1);
    repeat (4) step();
    chk_log("slt", 0, 1, h0 + 2, 32'd1, 1'b0);
    chk_log("badcode", 1, 1, h1 + 2, 32'd0, 1'b1);

    // Reset during EXEC aborts the response; tie afterwards goes to 0.
    clear_log();
    issue(0, ALU_AND, 32'hF, 32'h3, 1'b0, 10, 1'b0, h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    chk("abort_no_rsp", 32'(log_port.size()), 32'd0);
    fork
      issue(0, ALU_AND, 32'hF, 32'h3, 1'b0, 10, 1'b0, h0);
      issue(1, ALU_NOR, 32'd0, 32'd0, 1'b0, 10, 1'b0, h1);
    join
    repeat (4) step();
    chk_log("post_rst_r0", 0, 0, h0 + 2, 32'h3, 1'b0);
    chk_log("post_rst_r1", 1, 1, h0 + 5, 32'hFFFF_FFFF, 1'b0);

    // Random traffic on both requesters against the model.
    do_reset();
    fork
      drive_random(0, 150);
      drive_random(1, 150);
    join
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
